// File: rtl/dmem_responder.sv
// ----------------------------------------------------------------------------
// dmem_responder
//   Memory side of the core's load/store port. Accepts one request at a time
//   over a valid/ready handshake and returns exactly one response. Storage is
//   a word-organised RAM split into four byte lanes so SB/SH/SW can write only
//   the addressed bytes. Loads return LB/LH/LW/LBU/LHU results extended to 32
//   bits. A programmable number of wait states sits between accept and
//   execute so the core's stall logic can be exercised.
//
// Parameters
//   DEPTH_WORDS  RAM depth in 32-bit words (power of 2)
//   WAIT_CYCLES  extra cycles between accept and response (0..15)
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous, active-low reset
//   req_valid  request present
//   req_ready  responder can accept (registered, high only in IDLE)
//   req_we     1 = store, 0 = load
//   req_size   RV32 funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU
//   req_addr   byte address; upper bits beyond the RAM alias
//   req_wdata  right-aligned store data
//   rsp_valid  response present, held until rsp_ready
//   rsp_ready  core accepts the response
//   rsp_rdata  load result (0 for stores and errors)
//   rsp_err    access error
//
// Configuration macro
//   DMEM_MISALIGN_CHECK_EN  when defined, misaligned H/HU/W accesses respond
//                           with rsp_err=1 and leave the RAM untouched; when
//                           undefined, low address bits are ignored so the
//                           access snaps to natural alignment.
// ----------------------------------------------------------------------------
module dmem_responder #(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_size,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_EXEC,
    ST_RESP
  } state_t;

  state_t        state_reg;
  logic [3:0]    cnt_reg;
  logic          we_reg;
  logic [2:0]    size_reg;
  logic [AW+1:0] addr_reg;
  logic [31:0]   wdata_reg;

  // Address bits above the RAM simply alias; fold them away here.
  logic unused_addr_bits;
  assign unused_addr_bits = ^req_addr[31:AW+2];

  // --------------------------------------------------------------------------
  // Access decode from the latched request
  // --------------------------------------------------------------------------
  logic        size_ok;
  logic        misalign;
  logic        acc_err;
  logic [3:0]  byte_en;
  logic [31:0] wr_data;
  logic        wr_en;
  logic [31:0] rd_word;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] load_data;
  logic [31:0] exec_rdata;

  always_comb begin
    size_ok = (size_reg == 3'b000) || (size_reg == 3'b001) ||
              (size_reg == 3'b010) || (size_reg == 3'b100) ||
              (size_reg == 3'b101);
`ifdef DMEM_MISALIGN_CHECK_EN
    misalign = ((size_reg[1:0] == 2'b01) && addr_reg[0]) ||
               ((size_reg[1:0] == 2'b10) && (addr_reg[1:0] != 2'b00));
`else
    misalign = 1'b0;
`endif
    acc_err = !size_ok || misalign;

    // Halves key only on addr[1] and words on nothing, which is what gives
    // natural alignment when the misalign check is compiled out.
    byte_en = 4'b0000;
    wr_data = wdata_reg;
    case (size_reg[1:0])
      2'b00: begin
        byte_en = 4'b0001 << addr_reg[1:0];
        wr_data = {4{wdata_reg[7:0]}};
      end
      2'b01: begin
        byte_en = addr_reg[1] ? 4'b1100 : 4'b0011;
        wr_data = {2{wdata_reg[15:0]}};
      end
      2'b10: byte_en = 4'b1111;
      default: byte_en = 4'b0000;
    endcase

    wr_en = (state_reg == ST_EXEC) && we_reg && !acc_err;

    byte_sel = 8'(rd_word >> {addr_reg[1:0], 3'b000});
    half_sel = addr_reg[1] ? rd_word[31:16] : rd_word[15:0];
    case (size_reg)
      3'b000:  load_data = {{24{byte_sel[7]}}, byte_sel};
      3'b001:  load_data = {{16{half_sel[15]}}, half_sel};
      3'b010:  load_data = rd_word;
      3'b100:  load_data = {24'd0, byte_sel};
      3'b101:  load_data = {16'd0, half_sel};
      default: load_data = 32'd0;
    endcase
    exec_rdata = (acc_err || we_reg) ? 32'd0 : load_data;
  end

  // --------------------------------------------------------------------------
  // Byte-lane RAM with registered read. In IDLE the read address follows the
  // incoming request so the word is already in rd_word by the EXEC edge, even
  // with zero wait states. No write can be pending at that point, so the
  // early read never sees stale data.
  // --------------------------------------------------------------------------
  logic [AW-1:0] rd_idx;
  assign rd_idx = (state_reg == ST_IDLE) ? req_addr[AW+1:2] : addr_reg[AW+1:2];

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      logic [7:0] mem [DEPTH_WORDS];
      logic [7:0] rd_lane;

      always_ff @(posedge clk) begin
        if (wr_en && byte_en[gi]) begin
          mem[addr_reg[AW+1:2]] <= wr_data[8*gi +: 8];
        end
        rd_lane <= mem[rd_idx];
      end

      assign rd_word[8*gi +: 8] = rd_lane;
    end
  endgenerate

  // --------------------------------------------------------------------------
  // Control FSM with registered handshake outputs
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= ST_IDLE;
      cnt_reg   <= 4'd0;
      we_reg    <= 1'b0;
      size_reg  <= 3'd0;
      addr_reg  <= '0;
      wdata_reg <= 32'd0;
      req_ready <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= 32'd0;
      rsp_err   <= 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (req_valid && req_ready) begin
            we_reg    <= req_we;
            size_reg  <= req_size;
            addr_reg  <= req_addr[AW+1:0];
            wdata_reg <= req_wdata;
            cnt_reg   <= WAIT_INIT;
            req_ready <= 1'b0;
            state_reg <= (WAIT_CYCLES > 0) ? ST_WAIT : ST_EXEC;
          end else begin
            req_ready <= 1'b1;
          end
        end
        ST_WAIT: begin
          cnt_reg <= cnt_reg - 4'd1;
          if (cnt_reg == 4'd1) begin
            state_reg <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          rsp_rdata <= exec_rdata;
          rsp_err   <= acc_err;
          rsp_valid <= 1'b1;
          state_reg <= ST_RESP;
        end
        ST_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            rsp_rdata <= 32'd0;
            rsp_err   <= 1'b0;
            req_ready <= 1'b1;
            state_reg <= ST_IDLE;
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// ----------------------------------------------------------------------------
// tb_dmem_responder
//   Randomized bench for dmem_responder against a byte-array reference model.
//   Every transaction checks latency, response contents, hold behaviour and
//   the return to IDLE. Directed cases cover sign/zero extension, byte-lane
//   merging, long response stalls, misalignment and reset mid-transaction.
// ----------------------------------------------------------------------------
module tb_dmem_responder;

  localparam int DEPTH = 256;
  localparam int W     = 3;
  localparam int NB    = DEPTH * 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [2:0]  req_size = 3'd0;
  logic [31:0] req_addr = 32'd0;
  logic [31:0] req_wdata = 32'd0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  dmem_responder #(
    .DEPTH_WORDS(DEPTH),
    .WAIT_CYCLES(W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_size  (req_size),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  logic [7:0] mdl [NB];

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference: memory as a flat byte array, accesses by byte count.
  function automatic void model_access(input logic we, input logic [2:0] size,
                                       input logic [31:0] addr, input logic [31:0] wdata,
                                       output logic [31:0] rdata, output logic err);
    int unsigned ba;
    int unsigned nb;
    logic [31:0] v;
    err   = (size == 3'd3) || (size == 3'd6) || (size == 3'd7);
`ifdef DMEM_MISALIGN_CHECK_EN
    if (!err && (((size[1:0] == 2'd1) && addr[0]) ||
                 ((size == 3'd2) && (addr[1:0] != 2'd0))))
      err = 1'b1;
`endif
    rdata = 32'd0;
    if (err) return;
    nb = (size[1:0] == 2'd0) ? 1 : (size[1:0] == 2'd1) ? 2 : 4;
    ba = ((addr % NB) / nb) * nb;
    if (we) begin
      for (int i = 0; i < int'(nb); i++) mdl[ba + i] = wdata[8*i +: 8];
    end else begin
      v = 32'd0;
      for (int i = 0; i < int'(nb); i++) v = v | (32'(mdl[ba + i]) << (8*i));
      if (!size[2] && nb < 4 && v[8*nb-1]) v = v | ~((32'd1 << (8*nb)) - 32'd1);
      rdata = v;
    end
  endfunction

  // One full transaction. Called and returns at a slot 1 time unit after a
  // rising edge.
  task automatic do_txn(input logic we, input logic [2:0] size, input logic [31:0] addr,
                        input logic [31:0] wdata, input int hold, input string tag);
    logic [31:0] er;
    logic        ee;
    logic        busy_ready;
    int          lat;
    int          guard;
    guard = 0;
    while (!req_ready && guard < 20) begin
      @(posedge clk); #1;
      guard++;
    end
    if (!req_ready) begin
      check_val({tag, "/ready_timeout"}, 32'd0, 32'd1);
      return;
    end
    req_valid = 1'b1;
    req_we    = we;
    req_size  = size;
    req_addr  = addr;
    req_wdata = wdata;
    rsp_ready = 1'($urandom_range(0, 1));
    @(posedge clk); #1;
    model_access(we, size, addr, wdata, er, ee);
    // Junk on the request bus while busy must be ignored.
    req_valid  = 1'($urandom_range(0, 1));
    req_we     = 1'($urandom);
    req_size   = 3'($urandom);
    req_addr   = $urandom;
    req_wdata  = $urandom;
    busy_ready = 1'b0;
    lat = 0;
    while (!rsp_valid && lat < 40) begin
      busy_ready = busy_ready | req_ready;
      rsp_ready  = 1'($urandom_range(0, 1));
      req_valid  = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      lat++;
    end
    check_val({tag, "/latency"}, 32'(lat), 32'(W + 1));
    check_val({tag, "/ready_busy"}, {31'd0, busy_ready}, 32'd0);
    check_val({tag, "/rdata"}, rsp_rdata, er);
    check_val({tag, "/err"}, {31'd0, rsp_err}, {31'd0, ee});
    for (int h = 0; h < hold; h++) begin
      rsp_ready = 1'b0;
      req_valid = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      check_val({tag, "/hold_valid"}, {31'd0, rsp_valid}, 32'd1);
      check_val({tag, "/hold_rdata"}, rsp_rdata, er);
      check_val({tag, "/hold_ready"}, {31'd0, req_ready}, 32'd0);
    end
    rsp_ready = 1'b1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    check_val({tag, "/done_valid"}, {31'd0, rsp_valid}, 32'd0);
    check_val({tag, "/done_rdata"}, rsp_rdata, 32'd0);
    check_val({tag, "/done_err"}, {31'd0, rsp_err}, 32'd0);
    check_val({tag, "/done_ready"}, {31'd0, req_ready}, 32'd1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_val({tag, "/req_ready"}, {31'd0, req_ready}, 32'd0);
    check_val({tag, "/rsp_valid"}, {31'd0, rsp_valid}, 32'd0);
    check_val({tag, "/rsp_rdata"}, rsp_rdata, 32'd0);
    check_val({tag, "/rsp_err"}, {31'd0, rsp_err}, 32'd0);
  endtask

  task automatic release_reset(input string tag);
    @(posedge clk); #1;
    rst = 1'b1;
    check_val({tag, "/ready_pre"}, {31'd0, req_ready}, 32'd0);
    @(posedge clk); #1;
    check_val({tag, "/ready_post"}, {31'd0, req_ready}, 32'd1);
  endtask

  initial begin
    logic [2:0]  sz;
    logic [31:0] ad;
    #2;
    check_reset_outputs("reset");
    repeat (2) @(posedge clk);
    #1;
    release_reset("reset");

    // Fill every word so the model knows the whole RAM.
    for (int w = 0; w < DEPTH; w++) do_txn(1'b1, 3'd2, 32'(w * 4), $urandom, 0, "preload");

    // Word store/load, byte merge, half store with extension.
    do_txn(1'b1, 3'd2, 32'h10, 32'hDEADBEEF, 0, "t1_sw");
    do_txn(1'b0, 3'd2, 32'h10, 32'd0, 1, "t1_lw");
    do_txn(1'b1, 3'd0, 32'h11, 32'h00000080, 0, "t2_sb");
    do_txn(1'b0, 3'd0, 32'h11, 32'd0, 0, "t2_lb");
    do_txn(1'b0, 3'd4, 32'h11, 32'd0, 0, "t2_lbu");
    do_txn(1'b0, 3'd2, 32'h10, 32'd0, 0, "t2_lw");
    do_txn(1'b1, 3'd1, 32'h22, 32'h00008001, 0, "t3_sh");
    do_txn(1'b0, 3'd1, 32'h22, 32'd0, 0, "t3_lh");
    do_txn(1'b0, 3'd5, 32'h22, 32'd0, 0, "t3_lhu");
    do_txn(1'b0, 3'd2, 32'h20, 32'd0, 0, "t3_lw");
    // Long response stall.
    do_txn(1'b0, 3'd2, 32'h10, 32'd0, 5, "t4_stall");
    // Misaligned accesses, unsupported size, aliased address.
    do_txn(1'b0, 3'd2, 32'h13, 32'd0, 0, "t5_lw_mis");
    do_txn(1'b1, 3'd1, 32'h21, 32'h0000ABCD, 0, "t5_sh_mis");
    do_txn(1'b0, 3'd2, 32'h20, 32'd0, 0, "t5_lw_chk");
    do_txn(1'b1, 3'd3, 32'h20, 32'hFFFFFFFF, 0, "bad_size_st");
    do_txn(1'b0, 3'd7, 32'h20, 32'd0, 0, "bad_size_ld");
    do_txn(1'b0, 3'd2, 32'(NB) + 32'h10, 32'd0, 0, "alias");

    // Reset during WAIT: the store must not commit.
    req_valid = 1'b1; req_we = 1'b1; req_size = 3'd2;
    req_addr  = 32'h30; req_wdata = 32'h12345678;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    check_reset_outputs("t6_rst_wait");
    release_reset("t6_rst_wait");
    do_txn(1'b0, 3'd2, 32'h30, 32'd0, 0, "t6_lw");

    // Reset during RESP drops the response.
    req_valid = 1'b1; req_we = 1'b0; req_size = 3'd2; req_addr = 32'h30;
    @(posedge clk); #1;
    req_valid = 1'b0;
    repeat (W + 1) @(posedge clk);
    #1;
    check_val("rst_resp/valid_before", {31'd0, rsp_valid}, 32'd1);
    rst = 1'b0;
    #1;
    check_reset_outputs("rst_resp");
    release_reset("rst_resp");

    // Random traffic.
    for (int n = 0; n < 300; n++) begin
      sz = 3'($urandom_range(0, 7));
      ad = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, NB - 1));
      do_txn(1'($urandom), sz, ad, $urandom, $urandom_range(0, 3), $sformatf("rnd%0d", n));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
